// File: rtl/hmac_verify_pkg.sv
// Shared types and constants for the HMAC verify path.
package hmac_verify_pkg;

  typedef enum logic [1:0] {
    PASS,
    WAIT_CHK,
    DRAIN
  } verify_state_t;

  localparam int DIGEST_BITS_DEFAULT = 256;
  localparam int STAT_WIDTH          = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hmac_tag_cmp.sv
// Combinational tag/id comparator, shared by the verify stages.
// A tag only counts as matching when the ids agree as well.
module hmac_tag_cmp
  import hmac_verify_pkg::*;
#(
  parameter int DIGEST_BITS = DIGEST_BITS_DEFAULT,
  parameter int ID_WIDTH    = 6
) (
  input  logic [DIGEST_BITS-1:0] tag_a,
  input  logic [DIGEST_BITS-1:0] tag_b,
  input  logic [ID_WIDTH-1:0]    id_a,
  input  logic [ID_WIDTH-1:0]    id_b,
  output logic                   match,
  output logic                   id_err
);

  assign id_err = (id_a != id_b);
  assign match  = (tag_a == tag_b) && !id_err;

endmodule

// File: rtl/hmac_tag_verify.sv
// Forwards the data stream through a single output register and checks the
// tag carried in each packet's last beat against the recomputed tag from
// the checksum stream, producing one verdict beat per packet.
// Optional build macro HMAC_TAG_VERIFY_STATS_EN adds saturating pass/fail
// counters on the result stream.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PASS     | forwarding payload beats; checksum stream held off
// WAIT_CHK | last beat parked in the output register, awaiting chk beat
// DRAIN    | last beat and verdict presented; wait until both accepted
module hmac_tag_verify
  import hmac_verify_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int ID_WIDTH    = 6,
  parameter int DIGEST_BITS = DIGEST_BITS_DEFAULT
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   inp_data,
  input  logic [DATA_WIDTH/8-1:0] inp_keep,
  input  logic [ID_WIDTH-1:0]     inp_id,
  input  logic                    inp_last,
  input  logic                    inp_valid,
  output logic                    inp_ready,
  input  logic [DATA_WIDTH-1:0]   chk_data,
  input  logic [DATA_WIDTH/8-1:0] chk_keep,
  input  logic [ID_WIDTH-1:0]     chk_id,
  input  logic                    chk_last,
  input  logic                    chk_valid,
  output logic                    chk_ready,
  output logic [DATA_WIDTH-1:0]   out,
  output logic [DATA_WIDTH/8-1:0] out_keep,
  output logic [ID_WIDTH-1:0]     out_id,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    res_match,
  output logic                    res_id_err,
  output logic [ID_WIDTH-1:0]     res_id,
  output logic                    res_valid,
  input  logic                    res_ready
`ifdef HMAC_TAG_VERIFY_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]   stat_pass_cnt,
  output logic [STAT_WIDTH-1:0]   stat_fail_cnt
`endif
);

  if (DIGEST_BITS > DATA_WIDTH) begin : g_bad_digest
    $error("hmac_tag_verify: DIGEST_BITS must not exceed DATA_WIDTH");
  end

  verify_state_t       state, state_nxt;
  logic [ID_WIDTH-1:0] held_id;
  logic                inp_hs, chk_hs, out_done, res_done;
  logic                cmp_match, cmp_id_err;

  // chk keep/last and the bits above the tag carry nothing for the compare.
  logic unused_chk;
  assign unused_chk = ^{chk_keep, chk_last, chk_data};

  // The tag of the last beat stays parked in the output register until the
  // verdict is issued, so it doubles as the held tag.
  hmac_tag_cmp #(
    .DIGEST_BITS(DIGEST_BITS),
    .ID_WIDTH   (ID_WIDTH)
  ) u_cmp (
    .tag_a (out[DIGEST_BITS-1:0]),
    .tag_b (chk_data[DIGEST_BITS-1:0]),
    .id_a  (held_id),
    .id_b  (chk_id),
    .match (cmp_match),
    .id_err(cmp_id_err)
  );

  // State register.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) state <= PASS;
    else         state <= state_nxt;
  end

  // Next-state decode and handshake readies; readies never look at the
  // opposite side's valid, only out_ready feeds inp_ready in PASS.
  always_comb begin
    state_nxt = state;
    inp_ready = 1'b0;
    chk_ready = 1'b0;
    inp_hs    = 1'b0;
    chk_hs    = 1'b0;
    out_done  = !out_valid || out_ready;
    res_done  = !res_valid || res_ready;
    case (state)
      PASS: begin
        inp_ready = areset && out_done;
        inp_hs    = inp_valid && inp_ready;
        if (inp_hs && inp_last) state_nxt = WAIT_CHK;
      end
      WAIT_CHK: begin
        chk_ready = 1'b1;
        chk_hs    = chk_valid;
        if (chk_valid) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_done && res_done) state_nxt = PASS;
      end
      default: state_nxt = PASS;
    endcase
  end

  // Output register and verdict register; each valid drops on its own accept.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      out        <= '0;
      out_keep   <= '0;
      out_id     <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      held_id    <= '0;
      res_match  <= 1'b0;
      res_id_err <= 1'b0;
      res_id     <= '0;
      res_valid  <= 1'b0;
    end else begin
      if (inp_hs) begin
        out       <= inp_data;
        out_keep  <= inp_keep;
        out_id    <= inp_id;
        out_last  <= inp_last;
        out_valid <= !inp_last;
        if (inp_last) held_id <= inp_id;
      end else if (chk_hs) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (chk_hs) begin
        res_valid  <= 1'b1;
        res_match  <= cmp_match;
        res_id_err <= cmp_id_err;
        res_id     <= held_id;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef HMAC_TAG_VERIFY_STATS_EN
  // Verdict counters, advanced when a result beat is accepted.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      stat_pass_cnt <= '0;
      stat_fail_cnt <= '0;
    end else if (res_valid && res_ready) begin
      if (res_match) stat_pass_cnt <= sat_inc(stat_pass_cnt);
      else           stat_fail_cnt <= sat_inc(stat_fail_cnt);
    end
  end
`else
  // Without statistics the verdict stream is the only record of results.
`endif

endmodule

// File: tb/tb_hmac_tag_verify.sv
// Directed bench for hmac_tag_verify: forwarding, tag/id verdicts, early
// checksum beats, output backpressure and reset in WAIT_CHK.
module tb_hmac_tag_verify;

  logic         aclk = 1'b0;
  logic         areset;
  logic [511:0] inp_data, chk_data, out;
  logic [63:0]  inp_keep, chk_keep, out_keep;
  logic [5:0]   inp_id, chk_id, out_id, res_id;
  logic         inp_last, inp_valid, inp_ready;
  logic         chk_last, chk_valid, chk_ready;
  logic         out_last, out_valid, out_ready;
  logic         res_match, res_id_err, res_valid, res_ready;
`ifdef HMAC_TAG_VERIFY_STATS_EN
  logic [31:0]  stat_pass_cnt, stat_fail_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  int out_hs_cnt = 0;
  int chk_hs_cnt = 0;
  int chk_before;

  localparam logic [255:0] TAG   = {32{8'hA5}};
  localparam logic [255:0] CHK_HI = {8{32'h0BAD_F00D}};

  always #5 aclk = ~aclk;

  hmac_tag_verify dut (
    .aclk(aclk), .areset(areset),
    .inp_data(inp_data), .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
    .inp_valid(inp_valid), .inp_ready(inp_ready),
    .chk_data(chk_data), .chk_keep(chk_keep), .chk_id(chk_id), .chk_last(chk_last),
    .chk_valid(chk_valid), .chk_ready(chk_ready),
    .out(out), .out_keep(out_keep), .out_id(out_id), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_match(res_match), .res_id_err(res_id_err), .res_id(res_id),
    .res_valid(res_valid), .res_ready(res_ready)
`ifdef HMAC_TAG_VERIFY_STATS_EN
    , .stat_pass_cnt(stat_pass_cnt), .stat_fail_cnt(stat_fail_cnt)
`endif
  );

  always @(posedge aclk) begin
    if (areset && out_valid && out_ready) out_hs_cnt <= out_hs_cnt + 1;
    if (areset && chk_valid && chk_ready) chk_hs_cnt <= chk_hs_cnt + 1;
  end

  function automatic logic [511:0] mk_beat(input logic [5:0] tid, input int k, input logic last);
    if (last) return {{8{24'hDEAD00, 8'(k)}}, TAG};
    return {16{8'hB0, 2'b00, tid, 8'(k), 8'h3C}};
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One packet with out_ready=res_ready=1; entered and left at a negedge in PASS.
  task automatic do_pkt(input int nb, input logic [5:0] tid, input logic flip,
                        input logic [5:0] cid, input logic exp_match, input logic exp_err);
    for (int k = 0; k < nb; k++) begin
      inp_valid = 1'b1;
      inp_data  = mk_beat(tid, k, k == nb - 1);
      inp_keep  = '1;
      inp_id    = tid;
      inp_last  = (k == nb - 1);
      #1 check("inp_ready_pass", inp_ready, 1'b1);
      @(negedge aclk);
      if (k < nb - 1) begin
        check("fwd_valid", out_valid, 1'b1);
        check("fwd_data", out, mk_beat(tid, k, 1'b0));
        check("fwd_last", out_last, 1'b0);
      end else begin
        check("last_parked", out_valid, 1'b0);
      end
    end
    inp_valid = 1'b0;
    check("wait_chk_ready", chk_ready, 1'b1);
    check("wait_inp_ready", inp_ready, 1'b0);
    chk_valid = 1'b1;
    chk_data  = {CHK_HI, TAG ^ 256'(flip)};
    chk_id    = cid;
    @(negedge aclk);
    chk_valid = 1'b0;
    check("last_valid", out_valid, 1'b1);
    check("last_flag", out_last, 1'b1);
    check("last_data", out, mk_beat(tid, nb - 1, 1'b1));
    check("res_valid", res_valid, 1'b1);
    check("res_match", res_match, exp_match);
    check("res_id_err", res_id_err, exp_err);
    check("res_id", res_id, tid);
    check("drain_chk_ready", chk_ready, 1'b0);
    @(negedge aclk);
    check("drained_out", out_valid, 1'b0);
    check("drained_res", res_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b0;
    inp_data = '0; inp_keep = '0; inp_id = '0; inp_last = 1'b0; inp_valid = 1'b0;
    chk_data = '0; chk_keep = '1; chk_id = '0; chk_last = 1'b1; chk_valid = 1'b0;
    out_ready = 1'b1; res_ready = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_inp_ready", inp_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_out", out, '0);
    areset = 1'b1;
    @(negedge aclk);
    check("idle_chk_ready", chk_ready, 1'b0);
    check("idle_out_id", out_id, 6'd0);
    check("idle_res_id", res_id, 6'd0);

    // Matching 3-beat packet, wrong tag bit 0, wrong chk id.
    do_pkt(3, 6'd5, 1'b0, 6'd5, 1'b1, 1'b0);
    do_pkt(3, 6'd5, 1'b1, 6'd5, 1'b0, 1'b0);
    do_pkt(3, 6'd5, 1'b0, 6'd3, 1'b0, 1'b1);

    // Checksum beat offered 10 cycles before its packet.
    chk_before = chk_hs_cnt;
    chk_valid = 1'b1;
    chk_data  = {CHK_HI, TAG};
    chk_id    = 6'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("early_chk_held", chk_ready, 1'b0);
    end
    do_pkt(3, 6'd5, 1'b0, 6'd5, 1'b1, 1'b0);
    check("early_chk_once", chk_hs_cnt - chk_before, 1);

    // Output backpressure for 4 cycles while the verdict is taken at once.
    out_ready = 1'b0;
    inp_valid = 1'b1; inp_data = mk_beat(6'd7, 0, 1'b1); inp_id = 6'd7; inp_last = 1'b1;
    #1 check("bp_inp_ready", inp_ready, 1'b1);
    @(negedge aclk);
    inp_valid = 1'b0;
    check("bp_chk_ready", chk_ready, 1'b1);
    chk_valid = 1'b1; chk_data = {CHK_HI, TAG}; chk_id = 6'd7;
    @(negedge aclk);
    chk_valid = 1'b0;
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_res_valid", res_valid, 1'b1);
    check("bp_res_match", res_match, 1'b1);
    inp_valid = 1'b1; inp_data = mk_beat(6'd9, 0, 1'b1); inp_id = 6'd9; inp_last = 1'b1;
    @(negedge aclk);
    check("bp_res_first", res_valid, 1'b0);
    check("bp_out_held", out_valid, 1'b1);
    check("bp_out_data", out, mk_beat(6'd7, 0, 1'b1));
    check("bp_inp_blocked", inp_ready, 1'b0);
    @(negedge aclk);
    check("bp_out_held2", out_valid, 1'b1);
    check("bp_inp_blocked2", inp_ready, 1'b0);
    @(negedge aclk);
    check("bp_out_held3", out_valid, 1'b1);
    out_ready = 1'b1;
    #1 check("bp_exit_inp_ready", inp_ready, 1'b0);
    @(negedge aclk);
    check("bp_out_taken", out_valid, 1'b0);
    do_pkt(1, 6'd9, 1'b0, 6'd9, 1'b1, 1'b0);
    check("beat_count", out_hs_cnt, 14);
`ifdef HMAC_TAG_VERIFY_STATS_EN
    check("stat_pass_pre", stat_pass_cnt, 32'd4);
    check("stat_fail_pre", stat_fail_cnt, 32'd2);
`endif

    // Reset while waiting for the checksum, then a clean single-beat packet.
    inp_valid = 1'b1; inp_data = mk_beat(6'd2, 0, 1'b1); inp_id = 6'd2; inp_last = 1'b1;
    @(negedge aclk);
    inp_valid = 1'b0;
    check("rw_chk_ready", chk_ready, 1'b1);
    #2 areset = 1'b0;
    #1;
    check("rw_chk_ready_rst", chk_ready, 1'b0);
    check("rw_inp_ready_rst", inp_ready, 1'b0);
    check("rw_out_valid_rst", out_valid, 1'b0);
    check("rw_res_valid_rst", res_valid, 1'b0);
    check("rw_out_rst", out, '0);
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    do_pkt(1, 6'd2, 1'b0, 6'd2, 1'b1, 1'b0);
    check("beat_count_end", out_hs_cnt, 15);
`ifdef HMAC_TAG_VERIFY_STATS_EN
    check("stat_pass_post", stat_pass_cnt, 32'd1);
    check("stat_fail_post", stat_fail_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
